// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM and its control-output decoder.
package control_fsm_pkg;

  localparam int STATE_W = 4;
  localparam int OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
  endfunction

endpackage

// File: rtl/ctrl_perf_cnt.sv
// Free-running performance counter: +1 on each clock with inc_en high, wraps silently.
module ctrl_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/control_fsm.sv
// Multicycle instruction sequencer; retire/illegal pulses decoded from state.
// CTRL_FSM_PERF_EN adds cycle and retired-instruction counters.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic               illegal_op
`ifdef CTRL_FSM_PERF_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;

  always_comb begin
    state_d = S_FETCH;
    op_d    = op_q;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // op_q, not the live opcode, selects the access: the IR may already be changing
      S_MEMADR:  state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: instr_done = 1'b1;
      S_MEMWR:  instr_done = mem_ready;
      S_DECODE: illegal_op = !op_supported(opcode);
      S_FETCH, S_MEMADR, S_MEMRD, S_EXECUTE, S_ADDIEX: ;
      // unused encodings 12-15 flag and recover through FETCH
      default:  illegal_op = 1'b1;
    endcase
  end

  assign state = state_q;

`ifdef CTRL_FSM_PERF_EN
  ctrl_perf_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (1'b1),
    .cnt    (cycle_cnt)
  );

  ctrl_perf_cnt #(.W(CNT_W)) u_instr_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (instr_done),
    .cnt    (instr_cnt)
  );
`else
  // CNT_W stays validated so both builds accept the same parameter set
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-instruction expected traces plus literal sequence checks.
module tb_control_fsm;
  import control_fsm_pkg::*;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic [3:0]       state;
  logic             instr_done;
  logic             illegal_op;
`ifdef CTRL_FSM_PERF_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
`endif

  control_fsm #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
`ifdef CTRL_FSM_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [3:0]       exp_state;
  logic             exp_done, exp_ill;
  logic [CNT_W-1:0] exp_cyc, exp_ins;
  logic             chk_en = 1'b0;
  logic             rec_en = 1'b0;
  int               seen_s[$];
  int               seen_d[$];
  int               seen_i[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: outputs versus the trace model, half a cycle after each update edge
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("state", 32'(state), 32'(exp_state));
      chk("instr_done", 32'(instr_done), 32'(exp_done));
      chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
`ifdef CTRL_FSM_PERF_EN
      chk("cycle_cnt", 32'(cycle_cnt), 32'(exp_cyc));
      chk("instr_cnt", 32'(instr_cnt), 32'(exp_ins));
`endif
      if (rec_en) begin
        seen_s.push_back(int'(state));
        seen_d.push_back(int'(instr_done));
        seen_i.push_back(int'(illegal_op));
      end
    end
  end

  // One clock of stimulus with the outputs the model says must appear in it
  task automatic step(input logic [3:0] st, input logic mr, input logic dn, input logic il,
                      input logic [5:0] op);
    opcode    = op;
    mem_ready = mr;
    exp_state = st;
    exp_done  = dn;
    exp_ill   = il;
    chk_en    = 1'b1;
    @(posedge clk);
    exp_cyc = exp_cyc + 1'b1;
    if (dn) exp_ins = exp_ins + 1'b1;
    @(negedge clk);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  task automatic idle();
    step(S_FETCH, 1'b0, 1'b0, 1'b0, rnd_op());
  endtask

  // Whole instruction: fw fetch stalls, mw memory stalls
  task automatic run(input logic [5:0] op, input int fw, input int mw);
    logic sup;
    sup = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
          (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    for (int i = 0; i < fw; i++) step(S_FETCH, 1'b0, 1'b0, 1'b0, rnd_op());
    step(S_FETCH, 1'b1, 1'b0, 1'b0, rnd_op());
    step(S_DECODE, rnd_bit(), 1'b0, !sup, op);
    case (op)
      6'b100011: begin
        step(S_MEMADR, rnd_bit(), 1'b0, 1'b0, rnd_op());
        for (int i = 0; i < mw; i++) step(S_MEMRD, 1'b0, 1'b0, 1'b0, rnd_op());
        step(S_MEMRD, 1'b1, 1'b0, 1'b0, rnd_op());
        step(S_MEMWB, rnd_bit(), 1'b1, 1'b0, rnd_op());
      end
      6'b101011: begin
        step(S_MEMADR, rnd_bit(), 1'b0, 1'b0, rnd_op());
        for (int i = 0; i < mw; i++) step(S_MEMWR, 1'b0, 1'b0, 1'b0, rnd_op());
        step(S_MEMWR, 1'b1, 1'b1, 1'b0, rnd_op());
      end
      6'b000000: begin
        step(S_EXECUTE, rnd_bit(), 1'b0, 1'b0, rnd_op());
        step(S_ALUWB, rnd_bit(), 1'b1, 1'b0, rnd_op());
      end
      6'b000100: step(S_BRANCH, rnd_bit(), 1'b1, 1'b0, rnd_op());
      6'b001000: begin
        step(S_ADDIEX, rnd_bit(), 1'b0, 1'b0, rnd_op());
        step(S_ADDIWB, rnd_bit(), 1'b1, 1'b0, rnd_op());
      end
      6'b000010: step(S_JUMP, rnd_bit(), 1'b1, 1'b0, rnd_op());
      default: ;
    endcase
  endtask

  task automatic chk_trace(input string nm, input int es[$], input int ed[$], input int ei[$]);
    chk({nm, "_len"}, 32'(seen_s.size()), 32'(es.size()));
    for (int i = 0; i < es.size() && i < seen_s.size(); i++) begin
      chk({nm, "_state"}, 32'(seen_s[i]), 32'(es[i]));
      chk({nm, "_done"},  32'(seen_d[i]), 32'(ed[i]));
      chk({nm, "_ill"},   32'(seen_i[i]), 32'(ei[i]));
    end
    seen_s.delete();
    seen_d.delete();
    seen_i.delete();
  endtask

  task automatic chk_in_reset(input string nm);
    chk({nm, "_state"}, 32'(state), 32'd0);
    chk({nm, "_done"},  32'(instr_done), 32'd0);
    chk({nm, "_ill"},   32'(illegal_op), 32'd0);
`ifdef CTRL_FSM_PERF_EN
    chk({nm, "_cycle_cnt"}, 32'(cycle_cnt), 32'd0);
    chk({nm, "_instr_cnt"}, 32'(instr_cnt), 32'd0);
`endif
  endtask

  // Assert reset between edges, hold it across an edge, release on a falling edge
  task automatic do_reset(input string nm);
    chk_en = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_in_reset({nm, "_async"});
    mem_ready = 1'b1;
    opcode    = 6'b100011;
    @(posedge clk);
    #1 chk_in_reset({nm, "_held"});
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cyc = '0;
    exp_ins = '0;
  endtask

  int es[$], ed[$], ei[$];
`ifdef CTRL_FSM_PERF_EN
  logic [CNT_W-1:0] c0, i0;
`endif

  initial begin
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    opcode    = '0;
    exp_cyc   = '0;
    exp_ins   = '0;
    @(negedge clk);
    do_reset("reset");

    // lw with memory always ready
    rec_en = 1'b1;
    run(6'b100011, 0, 0);
    idle();
    rec_en = 1'b0;
    es = '{0, 1, 2, 3, 4, 0}; ed = '{0, 0, 0, 0, 1, 0}; ei = '{0, 0, 0, 0, 0, 0};
    chk_trace("lw_seq", es, ed, ei);

    // R-type with three fetch stalls
`ifdef CTRL_FSM_PERF_EN
    c0 = cycle_cnt; i0 = instr_cnt;
`endif
    rec_en = 1'b1;
    run(6'b000000, 3, 0);
`ifdef CTRL_FSM_PERF_EN
    chk("rtype_cycle_delta", 32'(CNT_W'(cycle_cnt - c0)), 32'd7);
    chk("rtype_instr_delta", 32'(CNT_W'(instr_cnt - i0)), 32'd1);
`endif
    idle();
    rec_en = 1'b0;
    es = '{0, 0, 0, 0, 1, 6, 7, 0}; ed = '{0, 0, 0, 0, 0, 0, 1, 0}; ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_trace("rtype_seq", es, ed, ei);

    // sw with two write stalls
    rec_en = 1'b1;
    run(6'b101011, 0, 2);
    idle();
    rec_en = 1'b0;
    es = '{0, 1, 2, 5, 5, 5, 0}; ed = '{0, 0, 0, 0, 0, 1, 0}; ei = '{0, 0, 0, 0, 0, 0, 0};
    chk_trace("sw_seq", es, ed, ei);

    // unsupported opcode is dropped
`ifdef CTRL_FSM_PERF_EN
    i0 = instr_cnt;
`endif
    rec_en = 1'b1;
    run(6'b111111, 0, 0);
    idle();
    rec_en = 1'b0;
    es = '{0, 1, 0}; ed = '{0, 0, 0}; ei = '{0, 1, 0};
    chk_trace("illegal_seq", es, ed, ei);
`ifdef CTRL_FSM_PERF_EN
    chk("illegal_instr_delta", 32'(CNT_W'(instr_cnt - i0)), 32'd0);
`endif

    // beq and j retire in three cycles, addi in four
    rec_en = 1'b1;
    run(6'b000100, 0, 0);
    run(6'b000010, 0, 0);
    run(6'b001000, 0, 0);
    rec_en = 1'b0;
    es = '{0, 1, 8, 0, 1, 11, 0, 1, 9, 10};
    ed = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_trace("beq_j_addi_seq", es, ed, ei);

    // mixed traffic, model-checked only
    run(6'b100011, 2, 3);
    run(6'b000001, 1, 0);
    run(6'b101011, 0, 0);
    run(6'b001000, 2, 0);
    run(6'b100011, 0, 1);
    run(6'b000000, 0, 0);
    idle();

    // reset mid-MEMRD abandons the load
    step(S_FETCH, 1'b1, 1'b0, 1'b0, rnd_op());
    step(S_DECODE, 1'b0, 1'b0, 1'b0, 6'b100011);
    step(S_MEMADR, 1'b0, 1'b0, 1'b0, rnd_op());
    step(S_MEMRD, 1'b0, 1'b0, 1'b0, rnd_op());
    do_reset("mid_memrd");
    run(6'b000100, 0, 0);
    run(6'b100011, 0, 0);
    idle();

`ifdef CTRL_FSM_PERF_EN
    for (int n = 0; n < 300 && exp_cyc != {CNT_W{1'b1}}; n++) idle();
    chk("cycle_pre_wrap", 32'(cycle_cnt), 32'hFF);
    idle();
    chk("cycle_wrap", 32'(cycle_cnt), 32'h0);
    for (int n = 0; n < 300 && exp_ins != {CNT_W{1'b1}}; n++) run(6'b000100, 0, 0);
    chk("instr_pre_wrap", 32'(instr_cnt), 32'hFF);
    run(6'b000010, 0, 0);
    chk("instr_wrap", 32'(instr_cnt), 32'h0);
`endif

    idle();
    chk_en = 1'b0;
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 32, width of the performance counters.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port opcode, input, 6 bits: instr[31:26] from the instruction register.
REQ-005 The block SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-006 The block SHALL have port state, output, 4 bits: registered current state, feeding the control-output decoder.
REQ-007 The block SHALL have port instr_done, output, 1 bit: one-cycle pulse on the cycle an instruction retires.
REQ-008 The block SHALL have port illegal_op, output, 1 bit: one-cycle pulse on the cycle an unsupported opcode is decoded.
REQ-009 The block SHALL have ports cycle_cnt and instr_cnt, output, CNT_W bits each: performance counters, present only under CTRL_FSM_PERF_EN.

Function
REQ-010 States SHALL be encoded 0-11: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-011 FETCH SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-012 DECODE SHALL capture opcode into an internal register op_q.
REQ-013 DECODE SHALL branch on opcode as follows: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other -> FETCH.
REQ-014 MEMADR SHALL go to MEMRD if op_q=100011, else to MEMWR.
REQ-015 MEMRD SHALL hold while mem_ready=0 and go to MEMWB on mem_ready=1.
REQ-016 MEMWR SHALL hold while mem_ready=0 and go to FETCH on mem_ready=1.
REQ-017 The remaining transitions SHALL be unconditional: EXECUTE -> ALUWB, ADDIEX -> ADDIWB, and MEMWB, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
REQ-018 Encodings 12-15 SHALL go to FETCH on the next edge, assert illegal_op for that cycle, and not assert instr_done.
REQ-019 instr_done SHALL be 1, combinationally from state, in MEMWB, ALUWB, BRANCH, ADDIWB and JUMP, and in MEMWR while mem_ready=1.
REQ-020 illegal_op SHALL be 1 in DECODE when opcode is unsupported; the instruction is dropped, with no retirement.
REQ-021 Latency SHALL be, with mem_ready tied 1: lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles.
REQ-022 mem_ready SHALL be ignored outside FETCH, MEMRD and MEMWR.

Reset
REQ-023 While rst_n=0, regardless of clk: state=FETCH, op_q=0, and cycle_cnt=instr_cnt=0.
REQ-024 On rst_n deassertion, the first rising edge SHALL evaluate FETCH normally; reset mid-instruction SHALL abandon it with no instr_done.
REQ-025 instr_done and illegal_op SHALL read 0 during reset.

Configuration
REQ-026 With CTRL_FSM_PERF_EN defined, cycle_cnt SHALL increment every clock.
REQ-027 With CTRL_FSM_PERF_EN defined, instr_cnt SHALL increment on every cycle where instr_done=1.
REQ-028 Both counters SHALL wrap from all-ones to 0 silently.
REQ-029 Without CTRL_FSM_PERF_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold: the state-encoding constants (4 bits), the opcode constants (LW, SW, RTYPE, BEQ, ADDI, J), and the state width. The package SHALL be shared with the control-output decoder.
REQ-031 The perf counters SHALL be one sub-module, ctrl_perf_cnt, instantiated twice and only under CTRL_FSM_PERF_EN.

Verification
REQ-032 Reset, then lw (100011) with mem_ready=1 -> state sequence 0,1,2,3,4,0, and instr_done=1 only in state 4.
REQ-033 R-type (000000) with mem_ready held 0 for 3 cycles in FETCH -> FETCH for 4 cycles, then 1,6,7,0; instr_cnt +1, cycle_cnt +7.
REQ-034 sw (101011) with mem_ready=0 for 2 cycles in MEMWR -> 0,1,2,5,5,5,0, and instr_done only on the last MEMWR cycle.
REQ-035 Opcode 111111 in DECODE -> illegal_op=1 for one cycle, then FETCH; instr_cnt unchanged.
REQ-036 rst_n asserted low asynchronously mid-MEMRD -> state=0 immediately, no instr_done; with counters preloaded at 2^CNT_W-1, the next increment yields 0.
